// File: rtl/kernel_invoker_pkg.sv
// Shared types and default widths for the kernel invoker and its fork.
package kernel_invoker_pkg;

    localparam int DATA_W = 8;
    localparam int CYC_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/kernel_invoker_fork2.sv
// Eager two-way fork: issues one n token and one start token per job,
// each retiring independently on its own handshake.
module kernel_invoker_fork2 (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    input  logic n_ready,
    input  logic start_ready,
    output logic n_valid,
    output logic start_valid,
    output logic all_sent
);

    logic n_sent;
    logic start_sent;

    assign n_valid     = active && !n_sent;
    assign start_valid = active && !start_sent;

    // Counts a handshake completing this edge as already sent.
    assign all_sent = (n_sent || (n_valid && n_ready)) &&
                      (start_sent || (start_valid && start_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_sent     <= 1'b0;
            start_sent <= 1'b0;
        end else if (clear) begin
            n_sent     <= 1'b0;
            start_sent <= 1'b0;
        end else begin
            if (n_valid && n_ready)
                n_sent <= 1'b1;
            if (start_valid && start_ready)
                start_sent <= 1'b1;
        end
    end

endmodule

// File: rtl/kernel_invoker.sv
// Single-job launcher for an elastic kernel: forks n/start, joins out0/end,
// and returns the result with a saturating latency count.
module kernel_invoker
    import kernel_invoker_pkg::*;
#(
    parameter int DATA_W = kernel_invoker_pkg::DATA_W,
    parameter int CYC_W  = kernel_invoker_pkg::CYC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] arg,
    input  logic              arg_valid,
    output logic              arg_ready,
    output logic [DATA_W-1:0] n,
    output logic              n_valid,
    input  logic              n_ready,
    output logic              start_valid,
    input  logic              start_ready,
    input  logic [DATA_W-1:0] out0,
    input  logic              out0_valid,
    output logic              out0_ready,
    input  logic              end_valid,
    output logic              end_ready,
    output logic [DATA_W-1:0] res,
    output logic [CYC_W-1:0]  res_cycles,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output state_t            dbg_state
);

    // Handshakes: a token moves on valid && ready at a rising edge; every
    // valid this block raises stays high, with stable data, until it moves.

    state_t state;
    state_t state_nx;
    logic   got_out;
    logic   got_end;
    logic   arg_fire;
    logic   out_fire;
    logic   end_fire;
    logic   all_sent;
    logic   all_done;
    logic   run;

    assign run       = (state == RUN);
    // Gated by rst so arg_ready is low while reset is held.
    assign arg_ready = rst && (state == IDLE);
    assign arg_fire  = arg_valid && arg_ready;

    assign out0_ready = run && !got_out;
    assign end_ready  = run && !got_end;
    assign out_fire   = out0_valid && out0_ready;
    assign end_fire   = end_valid && end_ready;

    assign res_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    assign all_done = all_sent && (got_out || out_fire) && (got_end || end_fire);

    kernel_invoker_fork2 u_fork (
        .clk         (clk),
        .rst         (rst),
        .active      (run),
        .clear       (arg_fire),
        .n_ready     (n_ready),
        .start_ready (start_ready),
        .n_valid     (n_valid),
        .start_valid (start_valid),
        .all_sent    (all_sent)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (arg_fire) state_nx = RUN;
            RUN:     if (all_done) state_nx = RESP;
            RESP:    if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n          <= '0;
            res        <= '0;
            res_cycles <= '0;
            got_out    <= 1'b0;
            got_end    <= 1'b0;
        end else if (arg_fire) begin
            n          <= arg;
            res_cycles <= '0;
            got_out    <= 1'b0;
            got_end    <= 1'b0;
        end else if (run) begin
            if (res_cycles != '1)
                res_cycles <= res_cycles + 1'b1;
            if (out_fire) begin
                got_out <= 1'b1;
                res     <= out0;
            end
            if (end_fire)
                got_end <= 1'b1;
        end
    end

endmodule
